lf_conf_spi: RTL and testbench

LF_CONF_SPI -- requirements
Module: lf_conf_spi

---
 rtl/lf_conf_pkg.sv | 32 +++
 rtl/lf_sync2.sv | 27 ++
 rtl/lf_conf_spi.sv | 274 +++++++++++++++++++++++++++
 tb/tb_lf_conf_spi.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lf_conf_pkg.sv
// Shared definitions for the LF configuration SPI slave.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
//
// Holds the frame command codes, the major-mode codes, the readback register
// selects and the state type of the mode sequencer.
`timescale 1ns/1ps
package lf_conf_pkg;

    // Command field, top four bits of each SPI frame
    localparam logic [3:0] CMD_NOP    = 4'd0;
    localparam logic [3:0] CMD_CONF   = 4'd1;
    localparam logic [3:0] CMD_DIV    = 4'd2;
    localparam logic [3:0] CMD_THRESH = 4'd3;
    localparam logic [3:0] CMD_RB_SEL = 4'd4;

    // Major modes carried in the top three bits of the configuration word
    localparam logic [2:0] MODE_ADC         = 3'd0;
    localparam logic [2:0] MODE_EDGE_DETECT = 3'd1;
    localparam logic [2:0] MODE_PASSTHRU    = 3'd2;

    // Readback register selects
    localparam logic [1:0] RB_CONF   = 2'd0;
    localparam logic [1:0] RB_DIV    = 2'd1;
    localparam logic [1:0] RB_THRESH = 2'd2;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_QUIESCE = 1'b1
    } mode_state_e;

endpackage

// File: rtl/lf_sync2.sv
// Two-flop synchroniser for one asynchronous input bit.
// Latency: 2 pck0 cycles from pin to q.
// Backpressure: none; samples every cycle.
//
// Ports: pck0 clock, nrst async active-low reset (q resets to 0),
//        d asynchronous input, q synchronised output.
`timescale 1ns/1ps
module lf_sync2 (
    input  logic pck0,
    input  logic nrst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge pck0 or negedge nrst) begin
        if (!nrst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/lf_conf_spi.sv
// SPI configuration slave for the LF front end: decodes frames into config registers and sequences major-mode changes.
// Latency: decoded outputs update 3 pck0 cycles after ncs rises; mode switch adds QUIESCE_CYC idle cycles.
// Backpressure: none; the MCU paces frames, malformed frames are dropped with a frame_err pulse.
//
// Ports:
//   pck0, nrst            sole clock, async active-low reset
//   spck, ncs, mosi       asynchronous SPI pins from the MCU
//   miso                  readback data (constant 0 unless LF_CONF_READBACK_EN)
//   conf_word             committed configuration word, major mode in its top 3 bits
//   divisor               clock divisor
//   lf_ed_threshold       edge-detect threshold
//   major_mode            active major mode
//   mode_sel              one-hot enable of the active mode
//   mode_idle             high while no mode is enabled
//   frame_err             one-cycle pulse for a frame of the wrong length
//
// Optional feature macro: LF_CONF_READBACK_EN enables command 4 register readback on miso.
`timescale 1ns/1ps
module lf_conf_spi #(
    parameter int FRAME_W     = 16,
    parameter int CONF_W      = 9,
    parameter int NUM_MODES   = 3,
    parameter int QUIESCE_CYC = 4,
    parameter int DEF_DIV     = 95,
    parameter int DEF_THRESH  = 127
) (
    input  logic                 pck0,
    input  logic                 nrst,
    input  logic                 spck,
    input  logic                 ncs,
    input  logic                 mosi,
    output logic                 miso,
    output logic [CONF_W-1:0]    conf_word,
    output logic [7:0]           divisor,
    output logic [7:0]           lf_ed_threshold,
    output logic [2:0]           major_mode,
    output logic [NUM_MODES-1:0] mode_sel,
    output logic                 mode_idle,
    output logic                 frame_err
);

    import lf_conf_pkg::*;

    // Bit counter must be able to hold FRAME_W+1 so over-long frames are
    // distinguishable from exact ones.
    localparam int CNT_W = $clog2(FRAME_W + 2);
    localparam int QC_W  = (QUIESCE_CYC > 1) ? $clog2(QUIESCE_CYC) : 1;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_W + 1);
    localparam logic [QC_W-1:0]  QC_LOAD  = QC_W'(QUIESCE_CYC - 1);
    localparam logic [7:0]       DIV_RST  = 8'(DEF_DIV);
    localparam logic [7:0]       THR_RST  = 8'(DEF_THRESH);

    // ------------------------------------------------------------------
    // Pin synchronisation and edge detection
    // ------------------------------------------------------------------
    logic spck_s, ncs_s, mosi_s;
    logic spck_d, ncs_d;

    lf_sync2 u_sync_spck (.pck0(pck0), .nrst(nrst), .d(spck), .q(spck_s));
    lf_sync2 u_sync_ncs  (.pck0(pck0), .nrst(nrst), .d(ncs),  .q(ncs_s));
    lf_sync2 u_sync_mosi (.pck0(pck0), .nrst(nrst), .d(mosi), .q(mosi_s));

    logic spck_rise, ncs_rise, ncs_fall, shift_en;

    assign spck_rise = spck_s & ~spck_d;
    assign ncs_rise  = ncs_s & ~ncs_d;
    assign ncs_fall  = ~ncs_s & ncs_d;
    // A clock edge coinciding with chip-select release never belongs to the frame.
    assign shift_en  = ~ncs_s & spck_rise & ~ncs_rise;

    // ------------------------------------------------------------------
    // Frame capture
    // ------------------------------------------------------------------
    logic [FRAME_W-1:0] frame_q;
    logic [CNT_W-1:0]   bit_cnt;
    // Set only by an observed ncs falling edge, so a frame cut by reset (or the
    // ncs rise seen right after reset) is dropped instead of being decoded.
    logic               frame_active;

    always_ff @(posedge pck0 or negedge nrst) begin
        if (!nrst) begin
            spck_d       <= 1'b0;
            ncs_d        <= 1'b0;
            frame_q      <= '0;
            bit_cnt      <= '0;
            frame_active <= 1'b0;
        end else begin
            spck_d <= spck_s;
            ncs_d  <= ncs_s;

            if (shift_en) begin
                frame_q <= {frame_q[FRAME_W-2:0], mosi_s};
            end

            if (ncs_fall) begin
                bit_cnt <= shift_en ? CNT_W'(1) : '0;
            end else if (shift_en && bit_cnt != CNT_SAT) begin
                bit_cnt <= bit_cnt + CNT_W'(1);
            end

            if (ncs_fall) begin
                frame_active <= 1'b1;
            end else if (ncs_rise) begin
                frame_active <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame decode
    // ------------------------------------------------------------------
    logic       frame_done, frame_ok;
    logic [3:0] frame_cmd;
    logic [2:0] new_mode;
    logic       cmd_conf, cmd_div, cmd_thresh;

    assign frame_done = ncs_rise & frame_active;
    assign frame_ok   = frame_done & (bit_cnt == CNT_FULL);
    assign frame_cmd  = frame_q[FRAME_W-1 -: 4];
    assign new_mode   = frame_q[CONF_W-1 -: 3];
    assign cmd_conf   = frame_ok & (frame_cmd == CMD_CONF);
    assign cmd_div    = frame_ok & (frame_cmd == CMD_DIV);
    assign cmd_thresh = frame_ok & (frame_cmd == CMD_THRESH);

    always_ff @(posedge pck0 or negedge nrst) begin
        if (!nrst) begin
            conf_word       <= '0;
            divisor         <= DIV_RST;
            lf_ed_threshold <= THR_RST;
            frame_err       <= 1'b0;
        end else begin
            frame_err <= frame_done & ~frame_ok;

            if (cmd_conf) begin
                conf_word <= frame_q[CONF_W-1:0];
            end

            if (cmd_div) begin
                divisor <= frame_q[7:0];
            end

            // Entering edge-detect mode always starts from the default threshold.
            if (cmd_conf && new_mode == MODE_EDGE_DETECT) begin
                lf_ed_threshold <= THR_RST;
            end else if (cmd_thresh) begin
                lf_ed_threshold <= frame_q[7:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Mode sequencer: a mode change parks all modes for QUIESCE_CYC cycles
    // before the new major mode takes effect.
    // ------------------------------------------------------------------
    mode_state_e     state_q, state_d;
    logic [QC_W-1:0] q_cnt;
    logic [2:0]      pend_mode;
    logic            mode_change;

    // While quiescing, any configuration write restarts the wait and becomes
    // the pending mode, so the last write always wins.
    assign mode_change = cmd_conf & ((state_q == ST_QUIESCE) | (new_mode != major_mode));

    always_ff @(posedge pck0 or negedge nrst) begin
        if (!nrst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (mode_change) begin
                    state_d = ST_QUIESCE;
                end
            end
            ST_QUIESCE: begin
                if (mode_change) begin
                    state_d = ST_QUIESCE;
                end else if (q_cnt == '0) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_comb begin
        mode_sel  = '0;
        mode_idle = 1'b1;
        if (state_q == ST_RUN) begin
            for (int i = 0; i < NUM_MODES; i++) begin
                mode_sel[i] = (major_mode == 3'(i));
            end
            mode_idle = (int'(major_mode) >= NUM_MODES);
        end
    end

    always_ff @(posedge pck0 or negedge nrst) begin
        if (!nrst) begin
            q_cnt      <= '0;
            pend_mode  <= '0;
            major_mode <= '0;
        end else begin
            if (mode_change) begin
                q_cnt     <= QC_LOAD;
                pend_mode <= new_mode;
            end else if (state_q == ST_QUIESCE && q_cnt != '0) begin
                q_cnt <= q_cnt - QC_W'(1);
            end

            if (state_q == ST_QUIESCE && !mode_change && q_cnt == '0) begin
                major_mode <= pend_mode;
            end
        end
    end

    // ------------------------------------------------------------------
    // Readback
    // ------------------------------------------------------------------
`ifdef LF_CONF_READBACK_EN
    logic               spck_fall;
    logic [1:0]         rb_sel;
    logic               rb_pend;
    logic [FRAME_W-1:0] rb_val;
    logic [FRAME_W-1:0] rb_shift;

    assign spck_fall = ~spck_s & spck_d;

    // Selected register, MSB-aligned within a frame.
    always_comb begin
        rb_val = '0;
        case (rb_sel)
            RB_CONF:   rb_val[FRAME_W-1 -: CONF_W] = conf_word;
            RB_DIV:    rb_val[FRAME_W-1 -: 8]      = divisor;
            RB_THRESH: rb_val[FRAME_W-1 -: 8]      = lf_ed_threshold;
            default:   rb_val = '0;
        endcase
    end

    // The MSB is visible as soon as the next frame opens; each spck falling
    // edge advances to the next bit so the MCU samples it on the rising edge.
    always_ff @(posedge pck0 or negedge nrst) begin
        if (!nrst) begin
            rb_sel   <= '0;
            rb_pend  <= 1'b0;
            rb_shift <= '0;
        end else begin
            if (frame_ok && frame_cmd == CMD_RB_SEL) begin
                rb_sel  <= frame_q[1:0];
                rb_pend <= 1'b1;
            end else if (ncs_fall) begin
                rb_pend <= 1'b0;
            end

            if (ncs_fall) begin
                rb_shift <= rb_pend ? rb_val : '0;
            end else if (spck_fall && !ncs_s) begin
                rb_shift <= {rb_shift[FRAME_W-2:0], 1'b0};
            end
        end
    end

    assign miso = rb_shift[FRAME_W-1];
`else
    assign miso = 1'b0;
`endif

endmodule

// File: tb/tb_lf_conf_spi.sv
// Self-checking bench for lf_conf_spi: directed scenarios plus randomized frames
// against a register-level model. A second instance with a long quiesce window
// lets a full frame arrive while a mode change is still pending.
`timescale 1ns/1ps
module tb_lf_conf_spi;

    localparam int HALF   = 5;    // pck0 cycles per spck half period
    localparam int SLOW_Q = 300;  // quiesce length of the second instance

    logic pck0 = 1'b0;
    logic nrst, spck, ncs, mosi;

    logic       miso, mode_idle, frame_err;
    logic [8:0] conf_word;
    logic [7:0] divisor, lf_ed_threshold;
    logic [2:0] major_mode, mode_sel;

    logic       miso_s, mode_idle_s, frame_err_s;
    logic [8:0] conf_word_s;
    logic [7:0] divisor_s, lf_ed_threshold_s;
    logic [2:0] major_mode_s, mode_sel_s;

    lf_conf_spi dut (
        .pck0(pck0), .nrst(nrst), .spck(spck), .ncs(ncs), .mosi(mosi),
        .miso(miso), .conf_word(conf_word), .divisor(divisor),
        .lf_ed_threshold(lf_ed_threshold), .major_mode(major_mode),
        .mode_sel(mode_sel), .mode_idle(mode_idle), .frame_err(frame_err)
    );

    lf_conf_spi #(.QUIESCE_CYC(SLOW_Q)) dut_slow (
        .pck0(pck0), .nrst(nrst), .spck(spck), .ncs(ncs), .mosi(mosi),
        .miso(miso_s), .conf_word(conf_word_s), .divisor(divisor_s),
        .lf_ed_threshold(lf_ed_threshold_s), .major_mode(major_mode_s),
        .mode_sel(mode_sel_s), .mode_idle(mode_idle_s), .frame_err(frame_err_s)
    );

    always #5 pck0 = ~pck0;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int err_cnt = 0;
    int idle_s_cnt = 0;

    always @(posedge pck0) cyc++;
    always @(negedge pck0) if (frame_err === 1'b1) err_cnt++;
    always @(negedge pck0) if (mode_idle_s === 1'b1) idle_s_cnt++;

    // Reference model: register contents implied by the frames sent so far.
    logic [8:0] m_conf;
    logic [7:0] m_div, m_thr;
    logic [2:0] m_mode;
    int         m_err;

    task automatic model_reset();
        m_conf = '0; m_div = 8'd95; m_thr = 8'd127; m_mode = 3'd0; m_err = 0;
    endtask

    task automatic model_apply(input logic [31:0] f, input int n);
        if (n != 16) begin
            m_err++;
        end else begin
            case (f[15:12])
                4'd1: begin
                    m_conf = f[8:0];
                    m_mode = f[8:6];
                    if (f[8:6] == 3'd1) m_thr = 8'd127;
                end
                4'd2: m_div = f[7:0];
                4'd3: m_thr = f[7:0];
                default: ;
            endcase
        end
    endtask

    // Opens a frame and clocks n bits MSB first; ncs is left low. miso is
    // sampled just before each rising spck edge, as the MCU would.
    task automatic spi_bits(input logic [31:0] f, input int n, output logic [31:0] rx);
        rx = '0;
        repeat (3) @(negedge pck0);
        ncs = 1'b0;
        repeat (HALF) @(negedge pck0);
        for (int i = n - 1; i >= 0; i--) begin
            mosi = f[i];
            repeat (HALF) @(negedge pck0);
            rx   = {rx[30:0], miso};
            spck = 1'b1;
            repeat (HALF) @(negedge pck0);
            spck = 1'b0;
        end
        repeat (HALF) @(negedge pck0);
    endtask

    task automatic send(input logic [31:0] f, input int n);
        logic [31:0] rx;
        spi_bits(f, n, rx);
        ncs = 1'b1;
        model_apply(f, n);
        repeat (12) @(negedge pck0);
    endtask

    task automatic test_reset();
        nrst = 1'b0; ncs = 1'b1; spck = 1'b0; mosi = 1'b0;
        model_reset();
        repeat (3) @(negedge pck0);
        total++; if (conf_word !== 9'h000) begin bad++; $display("FAIL rst_conf: got %h want %h", conf_word, 9'h000); end
        total++; if (divisor !== 8'd95) begin bad++; $display("FAIL rst_div: got %h want %h", divisor, 8'd95); end
        total++; if (lf_ed_threshold !== 8'd127) begin bad++; $display("FAIL rst_thr: got %h want %h", lf_ed_threshold, 8'd127); end
        total++; if (major_mode !== 3'd0) begin bad++; $display("FAIL rst_mode: got %h want %h", major_mode, 3'd0); end
        total++; if (mode_sel !== 3'b001) begin bad++; $display("FAIL rst_sel: got %b want %b", mode_sel, 3'b001); end
        total++; if (mode_idle !== 1'b0) begin bad++; $display("FAIL rst_idle: got %b want 0", mode_idle); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL rst_err: got %b want 0", frame_err); end
        total++; if (miso !== 1'b0) begin bad++; $display("FAIL rst_miso: got %b want 0", miso); end
        nrst = 1'b1;
        repeat (10) @(negedge pck0);
        total++; if (err_cnt !== 0) begin bad++; $display("FAIL rst_no_err: got %0d want 0", err_cnt); end
    endtask

    task automatic test_reset_midframe();
        logic [31:0] rx;
        spi_bits(32'h20, 8, rx);
        nrst = 1'b0;
        repeat (3) @(negedge pck0);
        nrst = 1'b1;
        model_reset();
        spi_bits(32'hAA, 8, rx);
        ncs = 1'b1;
        repeat (12) @(negedge pck0);
        total++; if (divisor !== 8'd95) begin bad++; $display("FAIL midrst_div: got %h want %h", divisor, 8'd95); end
        total++; if (conf_word !== 9'h000) begin bad++; $display("FAIL midrst_conf: got %h want %h", conf_word, 9'h000); end
        send(32'h2033, 16);
        total++; if (divisor !== m_div) begin bad++; $display("FAIL midrst_next_div: got %h want %h", divisor, m_div); end
    endtask

    task automatic test_divisor();
        logic [31:0] rx;
        logic [7:0]  old_div;
        old_div = m_div;
        spi_bits(32'h2040, 16, rx);
        ncs = 1'b1;
        model_apply(32'h2040, 16);
        repeat (2) @(negedge pck0);
        total++; if (divisor !== old_div) begin bad++; $display("FAIL div_early: got %h want %h", divisor, old_div); end
        @(negedge pck0);
        total++; if (divisor !== 8'h40) begin bad++; $display("FAIL div_on_time: got %h want %h", divisor, 8'h40); end
        repeat (10) @(negedge pck0);
        total++; if (err_cnt !== m_err) begin bad++; $display("FAIL div_no_err: got %0d want %0d", err_cnt, m_err); end
    endtask

    task automatic test_edge_mode();
        logic [31:0] rx;
        int idle, sel_bad;
        send(32'h3050, 16);
        total++; if (lf_ed_threshold !== 8'h50) begin bad++; $display("FAIL thr_write: got %h want %h", lf_ed_threshold, 8'h50); end
        spi_bits(32'h1040, 16, rx);
        ncs = 1'b1;
        model_apply(32'h1040, 16);
        idle = 0; sel_bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge pck0);
            if (mode_idle === 1'b1) begin
                idle++;
                if (mode_sel !== 3'b000) sel_bad++;
            end
        end
        total++; if (idle !== 4) begin bad++; $display("FAIL quiesce_len: got %0d want 4", idle); end
        total++; if (sel_bad !== 0) begin bad++; $display("FAIL quiesce_sel_zero: got %0d want 0", sel_bad); end
        total++; if (lf_ed_threshold !== 8'd127) begin bad++; $display("FAIL thr_reload: got %h want %h", lf_ed_threshold, 8'd127); end
        total++; if (mode_sel !== 3'b010) begin bad++; $display("FAIL edge_sel: got %b want %b", mode_sel, 3'b010); end
        total++; if (conf_word !== m_conf) begin bad++; $display("FAIL edge_conf: got %h want %h", conf_word, m_conf); end
    endtask

    task automatic test_bad_length();
        send(32'h2011, 15);
        total++; if (err_cnt !== m_err) begin bad++; $display("FAIL short_err: got %0d want %0d", err_cnt, m_err); end
        total++; if (divisor !== m_div) begin bad++; $display("FAIL short_div: got %h want %h", divisor, m_div); end
        send(32'h12011, 17);
        total++; if (err_cnt !== m_err) begin bad++; $display("FAIL long_err: got %0d want %0d", err_cnt, m_err); end
        total++; if (divisor !== m_div) begin bad++; $display("FAIL long_div: got %h want %h", divisor, m_div); end
        total++; if (conf_word !== m_conf) begin bad++; $display("FAIL long_conf: got %h want %h", conf_word, m_conf); end
        total++; if (lf_ed_threshold !== m_thr) begin bad++; $display("FAIL long_thr: got %h want %h", lf_ed_threshold, m_thr); end
    endtask

    task automatic test_quiesce_restart();
        logic [31:0] rx;
        int t1, t2, i0;
        repeat (SLOW_Q + 20) @(negedge pck0);
        total++; if (mode_sel_s !== 3'b010) begin bad++; $display("FAIL restart_pre_sel: got %b want %b", mode_sel_s, 3'b010); end
        i0 = idle_s_cnt;
        spi_bits(32'h1080, 16, rx);
        ncs = 1'b1; t1 = cyc;
        model_apply(32'h1080, 16);
        spi_bits(32'h1000, 16, rx);
        ncs = 1'b1; t2 = cyc;
        model_apply(32'h1000, 16);
        repeat (12) @(negedge pck0);
        total++; if (mode_idle_s !== 1'b1) begin bad++; $display("FAIL restart_still_idle: got %b want 1", mode_idle_s); end
        repeat (SLOW_Q + 20) @(negedge pck0);
        total++; if (idle_s_cnt - i0 !== (t2 - t1) + SLOW_Q) begin bad++; $display("FAIL restart_idle_len: got %0d want %0d", idle_s_cnt - i0, (t2 - t1) + SLOW_Q); end
        total++; if (mode_sel_s !== 3'b001) begin bad++; $display("FAIL restart_sel: got %b want %b", mode_sel_s, 3'b001); end
        total++; if (major_mode_s !== 3'd0) begin bad++; $display("FAIL restart_mode: got %h want 0", major_mode_s); end
        total++; if (mode_sel !== 3'b001) begin bad++; $display("FAIL restart_fast_sel: got %b want %b", mode_sel, 3'b001); end
    endtask

    task automatic test_readback();
        logic [31:0] rx;
        send(32'h205F, 16);
        send(32'h4001, 16);
        spi_bits(32'h0000, 16, rx);
        ncs = 1'b1;
        model_apply(32'h0000, 16);
        repeat (12) @(negedge pck0);
`ifdef LF_CONF_READBACK_EN
        total++; if (rx[15:0] !== 16'h5F00) begin bad++; $display("FAIL rb_div: got %h want %h", rx[15:0], 16'h5F00); end
        send(32'h4000, 16);
        spi_bits(32'h0000, 16, rx);
        ncs = 1'b1;
        model_apply(32'h0000, 16);
        repeat (12) @(negedge pck0);
        total++; if (rx[15:0] !== {m_conf, 7'b0}) begin bad++; $display("FAIL rb_conf: got %h want %h", rx[15:0], {m_conf, 7'b0}); end
`else
        total++; if (rx !== 32'h0) begin bad++; $display("FAIL rb_off_miso: got %h want 0", rx); end
`endif
        total++; if (divisor !== 8'h5F) begin bad++; $display("FAIL rb_divisor: got %h want %h", divisor, 8'h5F); end
        total++; if (conf_word !== m_conf) begin bad++; $display("FAIL rb_conf_kept: got %h want %h", conf_word, m_conf); end
    endtask

    task automatic test_random();
        logic [31:0] f, rx;
        logic [2:0]  exp_sel;
        int n, r;
        for (int k = 0; k < 40; k++) begin
            f = {15'b0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 12'($urandom)};
            r = $urandom_range(0, 5);
            n = (r == 0) ? 15 : (r == 1) ? 17 : 16;
            spi_bits(f, n, rx);
            ncs = 1'b1;
            model_apply(f, n);
            repeat (12) @(negedge pck0);
            exp_sel = (m_mode < 3) ? (3'b001 << m_mode) : 3'b000;
            total++; if (conf_word !== m_conf) begin bad++; $display("FAIL rnd_conf[%0d]: got %h want %h", k, conf_word, m_conf); end
            total++; if (divisor !== m_div) begin bad++; $display("FAIL rnd_div[%0d]: got %h want %h", k, divisor, m_div); end
            total++; if (lf_ed_threshold !== m_thr) begin bad++; $display("FAIL rnd_thr[%0d]: got %h want %h", k, lf_ed_threshold, m_thr); end
            total++; if (major_mode !== m_mode) begin bad++; $display("FAIL rnd_mode[%0d]: got %h want %h", k, major_mode, m_mode); end
            total++; if (mode_sel !== exp_sel) begin bad++; $display("FAIL rnd_sel[%0d]: got %b want %b", k, mode_sel, exp_sel); end
            total++; if (mode_idle !== (m_mode >= 3)) begin bad++; $display("FAIL rnd_idle[%0d]: got %b want %b", k, mode_idle, (m_mode >= 3)); end
            total++; if (err_cnt !== m_err) begin bad++; $display("FAIL rnd_err[%0d]: got %0d want %0d", k, err_cnt, m_err); end
`ifndef LF_CONF_READBACK_EN
            total++; if (rx !== 32'h0) begin bad++; $display("FAIL rnd_miso[%0d]: got %h want 0", k, rx); end
`endif
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_reset_midframe();
        test_divisor();
        test_edge_mode();
        test_bad_length();
        test_quiesce_restart();
        test_readback();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
